// File: rtl/tpu_out_drain_pkg.sv
// rtl/tpu_out_drain_pkg.sv - shared sizes and drain FSM state encodings
package tpu_out_drain_pkg;

  localparam int DATA_SIZE  = 8;
  localparam int LANES      = 4;
  localparam int WORD_SIZE  = LANES * DATA_SIZE;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_READ  = 2'd1,
    DRN_DRAIN = 2'd2,
    DRN_DONE  = 2'd3
  } drn_state_t;

endpackage

// File: rtl/tpu_out_drain_fifo.sv
// rtl/tpu_out_drain_fifo.sv - 2-entry skid FIFO between buffer read and output stream
module drain_fifo
  import tpu_out_drain_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WORD_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [WORD_SIZE-1:0] head_data,
  output logic [1:0]           count
);

  logic [WORD_SIZE-1:0] mem [2];
  logic                 rd_ptr;
  logic                 wr_ptr;

  // Storage, pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  // The credit logic upstream must never let the FIFO overflow or underflow
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && count == 2'd0));

endmodule

// File: rtl/tpu_out_drain.sv
// rtl/tpu_out_drain.sv - streams num_words buffer words from base_addr onto a valid/ready stream
module tpu_out_drain
  import tpu_out_drain_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    num_words,
  output logic [ADDR_W-1:0]    rd_index,
  input  logic [WORD_SIZE-1:0] rd_data,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  drn_state_t           state;
  drn_state_t           state_nxt;
  logic [ADDR_W-1:0]    base_reg;
  logic [ADDR_W-1:0]    num_reg;
  logic [ADDR_W-1:0]    issue_cnt;
  logic [ADDR_W-1:0]    pop_cnt;
  logic [ADDR_W-1:0]    rd_hold;
  logic                 inflight;
  logic [1:0]           fifo_count;
  logic [WORD_SIZE-1:0] head_data;
  logic                 pop;
  logic                 issue;
  logic                 start_ok;
  logic [2:0]           credit_use;

  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = head_data;
  assign out_last   = out_valid && (pop_cnt == num_reg - ADDR_W'(1));
  assign pop        = out_valid && out_ready;
  // A word popped this cycle frees its slot in time for the read issued now
  assign credit_use = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign rd_index   = issue ? (base_reg + issue_cnt) : rd_hold;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DRN_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read issue decision and status outputs
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_ok  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      DRN_IDLE, DRN_DONE: begin
        done = (state == DRN_DONE);
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = (num_words == '0) ? DRN_DONE : DRN_READ;
        end
      end
      DRN_READ: begin
        busy = 1'b1;
        if ((issue_cnt < num_reg) && (credit_use < 3'(FIFO_DEPTH))) begin
          issue = 1'b1;
          if (issue_cnt == num_reg - ADDR_W'(1)) begin
            state_nxt = DRN_DRAIN;
          end
        end
      end
      DRN_DRAIN: begin
        busy = 1'b1;
        if (!inflight && pop && out_last && fifo_count == 2'd1) begin
          state_nxt = DRN_DONE;
        end
      end
      default: state_nxt = DRN_IDLE;
    endcase
  end

  // Job registers, issue/pop counters and the one-cycle read-in-flight flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_reg  <= '0;
      num_reg   <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      rd_hold   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (start_ok) begin
        base_reg  <= base_addr;
        num_reg   <= num_words;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + ADDR_W'(1);
          rd_hold   <= rd_index;
        end
        if (pop) begin
          pop_cnt <= pop_cnt + ADDR_W'(1);
        end
      end
    end
  end

  drain_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (rd_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_tpu_out_drain.sv
// tb/tb_tpu_out_drain.sv - self-checking bench for tpu_out_drain
module tb_tpu_out_drain;
  import tpu_out_drain_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [ADDR_W-1:0]    base_addr = '0;
  logic [ADDR_W-1:0]    num_words = '0;
  logic [ADDR_W-1:0]    rd_index;
  logic [WORD_SIZE-1:0] rd_data = '0;
  logic                 out_valid;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_last;
  logic                 out_ready = 1'b1;
  logic                 busy;
  logic                 done;

  tpu_out_drain dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_words (num_words),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];

  // GBUFF_OUT model: one-cycle read latency
  always @(posedge clk) rd_data <= mem[rd_index];

  int          checks = 0;
  int          errors = 0;
  int          m_base = 0;
  int          m_num = 0;
  int          m_gen = 0;
  int          m_k = 0;
  bit          chk_en = 1'b0;
  int          ready_mode = 0;
  logic [31:0] m_last_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Stream scoreboard: word k of a drain must be mem[(base+k) mod 256]
  int   seen_gen = 0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;
  always @(negedge clk) begin
    if (m_gen != seen_gen) begin
      seen_gen = m_gen;
      m_k = 0;
    end
    if (!rst && chk_en) begin
      check("fifo_le_2", 32'(dut.u_fifo.count <= 2'd2), 32'd1);
      if (out_valid) begin
        if (m_k >= m_num) begin
          check("word_beyond_count", 32'(m_k < m_num), 32'd1);
        end else begin
          check("out_data", out_data, mem[(m_base + m_k) & 255]);
          check("out_last", 32'(out_last), 32'(m_k == m_num - 1));
        end
        if (prev_stall) begin
          check("stall_data_stable", out_data, prev_data);
          check("stall_last_stable", 32'(out_last), 32'(prev_last));
        end
        prev_stall = !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (out_ready) begin
          m_last_word = out_data;
          m_k++;
        end
      end else begin
        if (prev_stall) check("stall_valid_dropped", 32'(out_valid), 32'd1);
        prev_stall = 1'b0;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Consumer ready: always 1, or the repeating 1,0,0,1 pattern
  int tick = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick++;
      out_ready = (ready_mode == 0) || (tick % 4 == 0) || (tick % 4 == 3);
    end
  end

  task automatic drain(input int b, input int n, input int mode, input bit ignore_pulse);
    logic [ADDR_W-1:0] idx0;
    bit seen_done;
    ready_mode = mode;
    @(posedge clk);
    #2;
    idx0      = rd_index;
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    num_words = ADDR_W'(n);
    m_base    = b;
    m_num     = n;
    m_gen++;
    chk_en    = 1'b1;
    @(posedge clk);
    #2;
    if (ignore_pulse) begin
      base_addr = '0;
      num_words = ADDR_W'(7);
    end else begin
      start = 1'b0;
    end
    seen_done = 1'b0;
    for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
      @(negedge clk);
      if (cyc == 2) start = 1'b0;
      if (mode == 0 && cyc <= n) check("rd_index", 32'(rd_index), 32'((b + cyc - 1) & 255));
      if (mode == 0 && n > 0 && cyc <= 3) check("first_valid_latency", 32'(out_valid), 32'(cyc == 3));
      if (n == 0) check("num0_rd_index_held", 32'(rd_index), 32'(idx0));
      if (done) begin
        seen_done = 1'b1;
        if (mode == 0) check("done_cycle", 32'(cyc), 32'((n == 0) ? 1 : n + 3));
        check("busy_in_done", 32'(busy), 32'd0);
      end else begin
        check("busy_while_active", 32'(busy), 32'd1);
      end
    end
    if (!seen_done) check("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("done_level_held", 32'(done), 32'd1);
      check("idle_no_valid", 32'(out_valid), 32'd0);
    end
    check("word_count", 32'(m_k), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      if (i < 16) mem[i] = {4{8'(i)}};
      else        mem[i] = {8'hc0, 8'(i), ~8'(i), 8'(i)};
    end

    #1 rst = 1'b1;
    #20;
    check("rst_rd_index", 32'(rd_index), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    drain(0, 16, 0, 1'b0);
    check("last_word_literal", m_last_word, 32'h0f0f0f0f);

    drain(0, 16, 1, 1'b0);
    check("toggle_last_word_literal", m_last_word, 32'h0f0f0f0f);

    drain(0, 0, 0, 1'b0);

    drain(254, 4, 0, 1'b0);
    check("wrap_last_word_literal", m_last_word, 32'h01010101);

    ready_mode = 0;
    @(posedge clk);
    #2;
    start     = 1'b1;
    base_addr = '0;
    num_words = ADDR_W'(16);
    m_base    = 0;
    m_num     = 16;
    m_gen++;
    chk_en    = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int i = 0; i < 100 && m_k < 5; i++) @(negedge clk);
    check("reached_5_words", 32'(m_k >= 5), 32'd1);
    #2;
    rst    = 1'b1;
    chk_en = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    drain(0, 3, 0, 1'b0);
    check("post_rst_last_literal", m_last_word, 32'h02020202);

    drain(8, 2, 0, 1'b1);
    check("restart_last_literal", m_last_word, 32'h09090909);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_out_drain.md
Name: tpu_out_drain

Overview:
- Downstream stage of the TPU core: once the core asserts done, this block streams result words out of the output global buffer (GBUFF_OUT) to the host side.
- Reads `num_words` consecutive 32-bit words starting at `base_addr`, using the buffer's 1-cycle read latency.
- Presents the words on a valid/ready stream with a last flag, at full throughput when the consumer never stalls.

Parameters:
- DATA_SIZE, 8, bits per matrix element (one byte lane)
- WORD_SIZE, 32, bits per buffer word (4 lanes)
- ADDR_W, 8, global buffer index width
- FIFO_DEPTH, 2, skid FIFO entries; fixed at 2

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin drain; sampled in IDLE or DONE only
- base_addr  in  ADDR_W  first buffer index; captured on accepted start
- num_words  in  ADDR_W  words to drain; captured on accepted start; 0 is legal
- rd_index  out  ADDR_W  GBUFF_OUT index; owner holds GBUFF_OUT wr_en low while busy
- rd_data  in  WORD_SIZE  GBUFF_OUT data_out; valid the cycle after rd_index is presented
- out_valid  out  1  stream word valid
- out_data  out  WORD_SIZE  stream word; lane 0 = bits [7:0], unmodified buffer word
- out_last  out  1  high with the final word of a drain
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  high in READ or DRAIN
- done  out  1  high (level) in DONE until next accepted start

Behaviour:
- Interface convention (already decided): reset rst, asynchronous, active-high; clock clk.
- Reset values (async): state=IDLE; counters=0; FIFO empty; base/num regs=0. Outputs: rd_index=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- FSM states:
  - IDLE: start -> READ (num_words≠0) or DONE (num_words=0).
  - READ: issue reads; after the final issue -> DRAIN.
  - DRAIN: wait until in-flight=0, FIFO empty and the last word is handshaken -> DONE.
  - DONE: start behaves as in IDLE (restart allowed without reset).
- start is ignored in READ and DRAIN.
- Issue rule:
  - rd_index = base_reg + issue_cnt, modulo 2^ADDR_W (wrap at 255->0 is legal).
  - A read issues in a cycle iff state=READ, issue_cnt<num_reg, and fifo_count + inflight - pop < FIFO_DEPTH, where pop = out_valid&&out_ready that cycle.
  - On issue: issue_cnt+1; inflight=1 for the next cycle.
  - rd_index holds its last value when not issuing.
- Capture: in the cycle after an issue, rd_data is pushed into the FIFO at the clock edge. No push occurs without a prior issue. The credit rule guarantees no overflow; a push into a full FIFO is a design error (assertion).
- Output:
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - out_data and out_last are stable while out_valid && !out_ready.
  - out_last = head is word number num_reg-1 (tracked via pop_cnt).
- Latency: start accepted at edge E0. First rd_index in cycle after E0. First out_valid 2 cycles after that (3 cycles after the start cycle).
- Throughput: with out_ready held 1, one word per cycle. Total drain time = num_words + 3 cycles from start to DONE entry.
- Backpressure: out_ready=0 stalls issue once FIFO + inflight reach 2. No word is lost or duplicated.
- Simultaneous push and pop on a full FIFO is legal and count stays the same. Simultaneous push and pop on an empty FIFO cannot occur.
- Reset mid-operation: everything returns to reset values immediately and the FIFO contents are discarded.

Decomposition:
- Shared package (define.v additions): DATA_SIZE, WORD_SIZE, ADDR_W, and the state encodings DRN_IDLE=0, DRN_READ=1, DRN_DRAIN=2, DRN_DONE=3.
- One sub-module: drain_fifo, a 2-entry synchronous FIFO.
  - Ports: clk, rst, push, push_data, pop, head_data, count.
  - Async reset to empty.
- The top of the block holds the FSM, counters and credit logic.

Test Plan:
- GBUFF_OUT[i]=0x0i0i0i0i (i=0..15); base=0, num=16; ready held 1 -> out_valid first high 3 cycles after start; 16 consecutive words 0x00000000..0x0f0f0f0f; out_last on 0x0f0f0f0f; done high the following cycle.
- Same data; ready toggles 1,0,0,1 repeating -> same 16 words in order, none dropped or duplicated; out_data stable during stalls; FIFO never exceeds 2.
- num_words=0 with start -> DONE next cycle; out_valid never asserted; rd_index unchanged.
- base=254, num=4 -> rd_index sequence 254,255,0,1; output words match those entries.
- Mid-drain (after 5 words) assert rst for 1 cycle -> out_valid=0, busy=0, done=0 immediately. Then start base=0, num=3 -> clean 3-word stream with out_last on word 2.
- In DONE, start base=8, num=2 without reset -> 2 words from indices 8 and 9; start pulsed during READ is ignored (word count unchanged).
